pipe_ctrl: RTL and testbench

//  Stall/flush controller for the 3-stage (IF/ID/EX) pipeline. Drives the enable and

---
 rtl/pipe_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_ctrl.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// Stall/flush controller for a 3-stage IF/ID/EX pipe: en/flush are combinational (0 cycles),
// state/valids update on the next edge; multicycle EX ops freeze the whole pipe for STALL_CYC-1 cycles.
module pipe_ctrl #(
  parameter int RW        = 3,
  parameter int STALL_CYC = 2
) (
  input  logic          clk,
  input  logic          res,
  input  logic          start,
  input  logic          halt_req,
  input  logic          br_taken,
  input  logic          mc_op,
  input  logic [RW-1:0] id_rs1,
  input  logic [RW-1:0] id_rs2,
  input  logic [RW-1:0] ex_rd,
  input  logic          ex_we,
  input  logic          ex_load,
  output logic          pc_en,
  output logic          ifid_en,
  output logic          idex_en,
  output logic          ifid_flush,
  output logic          idex_flush,
  output logic          ifid_valid,
  output logic          idex_valid,
  output logic [1:0]    state
);

  localparam logic [1:0] S_HALT = 2'b00;
  localparam logic [1:0] S_RUN  = 2'b01;
  localparam logic [1:0] S_MCW  = 2'b10;

  // Counter only has to hold STALL_CYC-2; keep at least one bit for the degenerate cases.
  localparam int            CW       = (STALL_CYC > 2) ? $clog2(STALL_CYC - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = (STALL_CYC > 2) ? CW'(STALL_CYC - 2) : '0;
  localparam logic          MC_EN    = (STALL_CYC > 1);

  logic [1:0]    nxt;
  logic [CW-1:0] cnt;
  logic          halt_hit;
  logic          br_hit;
  logic          lu_hit;
  logic          mc_hit;
  logic          src_match;

  // A bubble in EX (idex_valid=0) must never raise a hazard; r0 is never a real producer.
  assign src_match = (ex_rd == id_rs1) || (ex_rd == id_rs2);
  assign halt_hit  = idex_valid && halt_req;
  assign br_hit    = idex_valid && br_taken;
  assign lu_hit    = idex_valid && ex_load && ex_we && (ex_rd != '0) && ifid_valid && src_match;
  assign mc_hit    = ifid_valid && mc_op && MC_EN;

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state <= S_HALT;
    end else begin
      state <= nxt;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      S_HALT: begin
        if (start) nxt = S_RUN;
      end
      S_RUN: begin
        if (halt_hit) begin
          nxt = S_HALT;
        end else if (!br_hit && !lu_hit && mc_hit) begin
          nxt = S_MCW;
        end
      end
      S_MCW: begin
        if (cnt == '0) nxt = S_RUN;
      end
      default: nxt = S_HALT;
    endcase
  end

  always_comb begin
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    idex_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (state == S_RUN) begin
      pc_en   = 1'b1;
      ifid_en = 1'b1;
      idex_en = 1'b1;
      if (halt_hit) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_en    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (br_hit) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (lu_hit) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      cnt <= '0;
    end else if (state == S_RUN && nxt == S_MCW) begin
      cnt <= CNT_INIT;
    end else if (state == S_MCW && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  // Flush wins over enable; ID/EX inherits the IF/ID valid bit as it advances.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      ifid_valid <= 1'b0;
      idex_valid <= 1'b0;
    end else begin
      if (ifid_flush)   ifid_valid <= 1'b0;
      else if (ifid_en) ifid_valid <= 1'b1;

      if (idex_flush)   idex_valid <= 1'b0;
      else if (idex_en) idex_valid <= ifid_valid;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a STALL_CYC=4 instance is fully checked, a STALL_CYC=1 twin must never freeze.
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       res;
  logic       start, halt_req, br_taken, mc_op, ex_we, ex_load;
  logic [2:0] id_rs1, id_rs2, ex_rd;

  logic       pc_en, ifid_en, idex_en, ifid_flush, idex_flush, ifid_valid, idex_valid;
  logic [1:0] state;
  logic       o1_pc_en, o1_ifid_en, o1_idex_en, o1_ifid_flush, o1_idex_flush;
  logic       o1_ifid_valid, o1_idex_valid;
  logic [1:0] o1_state;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.RW(3), .STALL_CYC(4)) u_dut (
    .clk(clk), .res(res), .start(start), .halt_req(halt_req), .br_taken(br_taken),
    .mc_op(mc_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_load(ex_load), .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .ifid_valid(ifid_valid),
    .idex_valid(idex_valid), .state(state)
  );

  pipe_ctrl #(.RW(3), .STALL_CYC(1)) u_one (
    .clk(clk), .res(res), .start(start), .halt_req(halt_req), .br_taken(br_taken),
    .mc_op(mc_op), .id_rs1(id_rs1), .id_rs2(id_rs2), .ex_rd(ex_rd), .ex_we(ex_we),
    .ex_load(ex_load), .pc_en(o1_pc_en), .ifid_en(o1_ifid_en), .idex_en(o1_idex_en),
    .ifid_flush(o1_ifid_flush), .idex_flush(o1_idex_flush), .ifid_valid(o1_ifid_valid),
    .idex_valid(o1_idex_valid), .state(o1_state)
  );

  // Observed bits: {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, ifid_valid, idex_valid, state}
  wire [8:0] obs = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, ifid_valid, idex_valid, state};

  typedef struct {
    logic       start, halt_req, br_taken, mc_op, ex_we, ex_load;
    logic [2:0] rs1, rs2, rd;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t mk(input logic st, input logic hr, input logic br, input logic mc,
                              input logic we, input logic ld, input logic [2:0] rs1,
                              input logic [2:0] rs2, input logic [2:0] rd, input logic [8:0] exp);
    vec_t v;
    v.start = st; v.halt_req = hr; v.br_taken = br; v.mc_op = mc;
    v.ex_we = we; v.ex_load = ld; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b want %b", name, act, exp);
    end
  endtask

  // Every full check also confirms the STALL_CYC=1 twin has never frozen.
  task automatic chk_all(input string name, input logic [8:0] exp);
    chk(name, obs, exp);
    chk({name, "_one_nofreeze"}, {8'd0, o1_state == 2'b10}, 9'd0);
  endtask

  task automatic idle_inputs();
    start = 1'b0; halt_req = 1'b0; br_taken = 1'b0; mc_op = 1'b0;
    ex_we = 1'b0; ex_load = 1'b0; id_rs1 = 3'd1; id_rs2 = 3'd2; ex_rd = 3'd5;
  endtask

  task automatic apply(input vec_t v);
    start = v.start; halt_req = v.halt_req; br_taken = v.br_taken; mc_op = v.mc_op;
    ex_we = v.ex_we; ex_load = v.ex_load; id_rs1 = v.rs1; id_rs2 = v.rs2; ex_rd = v.rd;
  endtask

  initial begin
    //                 st hr br mc we ld rs1   rs2   rd    expected
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b000_00_00_00); // halted
    tbl[1]  = mk(1, 0, 0, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b000_00_00_00); // start seen
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b111_00_00_01);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b111_00_10_01);
    tbl[4]  = mk(0, 0, 0, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b111_00_11_01);
    tbl[5]  = mk(0, 0, 0, 0, 1, 1, 3'd1, 3'd3, 3'd3, 9'b001_01_11_01); // load-use via rs2
    tbl[6]  = mk(0, 0, 0, 0, 1, 1, 3'd1, 3'd3, 3'd3, 9'b111_00_10_01); // bubble in EX: no repeat
    tbl[7]  = mk(0, 0, 0, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b111_00_11_01);
    tbl[8]  = mk(0, 0, 0, 0, 1, 1, 3'd0, 3'd2, 3'd0, 9'b111_00_11_01); // rd=0: no hazard
    tbl[9]  = mk(0, 0, 1, 0, 1, 1, 3'd3, 3'd2, 3'd3, 9'b111_11_11_01); // branch beats load-use
    tbl[10] = mk(0, 1, 1, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b111_00_00_01); // bubble ignores br/halt
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b111_00_10_01);
    tbl[12] = mk(0, 0, 0, 1, 0, 0, 3'd1, 3'd2, 3'd5, 9'b111_00_11_01); // mc entry advances
    tbl[13] = mk(0, 1, 1, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b000_00_11_10); // frozen, inputs ignored
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b000_00_11_10);
    tbl[15] = mk(0, 0, 0, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b000_00_11_10);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b111_00_11_01);
    tbl[17] = mk(0, 1, 0, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b000_11_11_01); // halt in EX
    tbl[18] = mk(0, 0, 0, 0, 0, 0, 3'd1, 3'd2, 3'd5, 9'b000_00_00_00);

    res = 1'b1;
    idle_inputs();
    #1 chk_all("reset_state", 9'b000_00_00_00);
    @(negedge clk);
    res = 1'b0;

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      apply(tbl[i]);
      #1 chk_all($sformatf("row%0d", i), tbl[i].exp);
    end

    // Reset mid-RUN with both valids set; reset also overrides start.
    @(negedge clk); idle_inputs(); start = 1'b1;
    #1 chk_all("a_start", 9'b000_00_00_00);
    @(negedge clk); start = 1'b0;
    #1 chk_all("a_run0", 9'b111_00_00_01);
    @(negedge clk); #1 chk_all("a_run1", 9'b111_00_10_01);
    @(negedge clk); #1 chk_all("a_run2", 9'b111_00_11_01);
    res = 1'b1;
    #1 chk("a_res_same", {obs[8:4], 2'b00, obs[1:0]}, 9'd0);
    start = 1'b1;
    @(negedge clk); #1 chk_all("a_res_next", 9'b000_00_00_00);
    @(negedge clk); #1 chk_all("a_res_beats_start", 9'b000_00_00_00);
    res = 1'b0;
    @(negedge clk); start = 1'b0;
    #1 chk_all("a_resume0", 9'b111_00_00_01);
    @(negedge clk); #1 chk_all("a_resume1", 9'b111_00_10_01);
    @(negedge clk); #1 chk_all("a_resume2", 9'b111_00_11_01);

    // Reset during MCWAIT (counter at 2), then restart must show no leftover freeze.
    @(negedge clk); mc_op = 1'b1;
    #1 chk_all("b_mc_entry", 9'b111_00_11_01);
    @(negedge clk); mc_op = 1'b0;
    #1 chk_all("b_mcw", 9'b000_00_11_10);
    res = 1'b1;
    #1 chk("b_res_same", {obs[8:4], 2'b00, obs[1:0]}, 9'd0);
    @(negedge clk); #1 chk_all("b_res_next", 9'b000_00_00_00);
    res = 1'b0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    #1 chk_all("b_resume0", 9'b111_00_00_01);
    @(negedge clk); #1 chk_all("b_resume1", 9'b111_00_10_01);
    @(negedge clk); #1 chk_all("b_resume2", 9'b111_00_11_01);
    @(negedge clk); mc_op = 1'b1;
    #1 chk_all("b_mc2_entry", 9'b111_00_11_01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); mc_op = 1'b0;
      #1 chk_all($sformatf("b_mc2_wait%0d", k), 9'b000_00_11_10);
    end
    @(negedge clk); #1 chk_all("b_mc2_done", 9'b111_00_11_01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
